// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types, widths and Booth step codes for the sequential multiplier
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Radix-2 recoding of the pair {Q[0], q_-1}
  function automatic logic [1:0] booth_code(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b10:   return BOOTH_SUB;
      2'b01:   return BOOTH_ADD;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth step: conditional add/sub then arithmetic right shift
module booth_step
  import mult_pkg::*;
#(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] q,
  input  logic         qm1,
  input  logic [N-1:0] m_ext,
  output logic [N-1:0] a_next,
  output logic [N-1:0] q_next,
  output logic         qm1_next
);

  logic [N-1:0] sum;

  // N-bit add/sub; the carry out is dropped on purpose
  always_comb begin
    sum = a;
    case (booth_code(q[0], qm1))
      BOOTH_ADD: sum = a + m_ext;
      BOOTH_SUB: sum = a - m_ext;
      default:   sum = a;
    endcase
  end

  assign a_next   = {sum[N-1], sum[N-1:1]};
  assign q_next   = {sum[0], q[N-1:1]};
  assign qm1_next = q[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - iterative radix-2 Booth multiplier with start/done handshake
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] low,
  output logic [WIDTH-1:0] high
);

  localparam int N  = WIDTH + 1;
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state;
  logic [N-1:0]    a_r, q_r, m_r;
  logic            qm1_r;
  logic [CW-1:0]   count;
  logic [N-1:0]    a_nx, q_nx;
  logic            qm1_nx;
  logic [2*N-1:0]  prod_nx;

  booth_step #(.N(N)) u_step (
    .a        (a_r),
    .q        (q_r),
    .qm1      (qm1_r),
    .m_ext    (m_r),
    .a_next   (a_nx),
    .q_next   (q_nx),
    .qm1_next (qm1_nx)
  );

  assign prod_nx = {a_nx, q_nx};
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      qm1_r <= 1'b0;
      count <= '0;
      done  <= 1'b0;
      low   <= '0;
      high  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // One extra bit keeps unsigned operands exact without a correction step
            m_r   <= {is_signed & m[WIDTH-1], m};
            q_r   <= {is_signed & q[WIDTH-1], q};
            a_r   <= '0;
            qm1_r <= 1'b0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_nx;
          q_r   <= q_nx;
          qm1_r <= qm1_nx;
          if (count == LAST) begin
            high  <= prod_nx[2*WIDTH-1:WIDTH];
            low   <= prod_nx[WIDTH-1:0];
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
